count_uart_tx: RTL and testbench

Downstream consumer of the 0–10 wrap counter. It watches the counter's 8-bit value, captures every change into a small FIFO, and serialises each captured value onto a UART-style line: start bit, data LSB first, optional parity, stop bit. It is the stage that exports the count off-chip.

---
 rtl/count_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_count_uart_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_uart_tx.sv
// count_uart_tx: captures every change of a counter value into a small FIFO and sends each
// captured word as a UART frame. Define COUNT_UART_TX_PARITY_EN to add an even-parity bit.
module count_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  tx,
   output logic                  busy,
   output logic                  fifo_full,
   output logic [7:0]            dropped_count
);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam int CYC_W = $clog2(CLKS_PER_BIT);

`ifdef COUNT_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic                  tx_q, tx_d;
   logic [DATA_WIDTH-1:0] prev_q, prev_d;
   logic [AW:0]           wr_q, wr_d;
   logic [AW:0]           rd_q, rd_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [7:0]            drop_q, drop_d;
`ifdef COUNT_UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   logic push_req, fifo_empty, full, pop, push_ok, cyc_last;

   always_comb begin
      push_req   = (data_in != prev_q);
      fifo_empty = (wr_q == rd_q);
      full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop        = (state_q == IDLE) && !fifo_empty;
      // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
      push_ok    = push_req && (!full || pop);
      cyc_last   = (cyc_q == CYC_W'(CLKS_PER_BIT - 1));
   end

   always_comb begin
      prev_d = prev_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      mem_d  = mem_q;
      drop_d = drop_q;
      if (push_req) prev_d = data_in;
      if (push_ok) begin
         mem_d[wr_q[AW-1:0]] = data_in;
         wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      end else if (push_req && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
      if (pop) rd_d = rd_q + {{AW{1'b0}}, 1'b1};
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      cyc_d   = cyc_q;
      tx_d    = 1'b1;
`ifdef COUNT_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      // tx_d follows the current state, so the line lags the state register by one cycle.
      case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_q[AW-1:0]];
               bit_d   = '0;
               cyc_d   = '0;
               state_d = START;
`ifdef COUNT_UART_TX_PARITY_EN
               par_d   = ^mem_q[rd_q[AW-1:0]];
`endif
            end
         end
         START: begin
            tx_d  = 1'b0;
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
            if (cyc_last) state_d = DATA;
         end
         DATA: begin
            tx_d  = shift_q[0];
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
            if (cyc_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef COUNT_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef COUNT_UART_TX_PARITY_EN
         PARITY: begin
            tx_d  = par_q;
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
            if (cyc_last) state_d = STOP;
         end
`endif
         STOP: begin
            tx_d  = 1'b1;
            cyc_d = cyc_last ? '0 : cyc_q + CYC_W'(1);
            if (cyc_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         cyc_q   <= '0;
         tx_q    <= 1'b1;
         prev_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         mem_q   <= '{default: '0};
         drop_q  <= '0;
`ifdef COUNT_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         cyc_q   <= cyc_d;
         tx_q    <= tx_d;
         prev_q  <= prev_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         mem_q   <= mem_d;
         drop_q  <= drop_d;
`ifdef COUNT_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx            = tx_q;
   assign busy          = (state_q != IDLE);
   assign fifo_full     = full;
   assign dropped_count = drop_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx with CLKS_PER_BIT=4; a line monitor decodes frames from tx.
module tb_count_uart_tx;
   localparam int CPB = 4;
`ifdef COUNT_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FS = NBITS * CPB;

   logic       clock;
   logic       reset_n;
   logic [7:0] data_in;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic [7:0] dropped_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_val_q[$];
   bit         rx_ok_q[$];
   bit         rx_busy_q[$];
   int         rx_gap_q[$];
   logic       rx_par_q[$];

   count_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .tx(tx),
      .busy(busy), .fifo_full(fifo_full), .dropped_count(dropped_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Line monitor: samples tx on falling edges and decodes one frame per start bit.
   bit          mon_active = 0;
   int          mon_idx = 0;
   int          mon_high = 0;
   int          mon_gap = 0;
   bit          mon_busy_ok = 0;
   logic [FS-1:0] mon_s;
   always @(negedge clock) begin
      if (!reset_n) begin
         mon_active = 0;
         mon_high   = 0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active  = 1;
            mon_s[0]    = 1'b0;
            mon_idx     = 1;
            mon_gap     = mon_high;
            mon_busy_ok = (busy === 1'b1);
         end else begin
            mon_high++;
         end
      end else begin
         mon_s[mon_idx] = tx;
         if (mon_idx < FS - 1 && busy !== 1'b1) mon_busy_ok = 0;
         if (mon_idx == FS - 1 && busy !== 1'b0) mon_busy_ok = 0;
         mon_idx++;
         if (mon_idx == FS) begin
            logic [7:0] v;
            bit ok;
            ok = (mon_s[0] === 1'b0) && (mon_s[(NBITS-1)*CPB] === 1'b1);
            for (int b = 0; b < NBITS; b++)
               for (int j = 0; j < CPB; j++)
                  if (mon_s[b*CPB+j] !== mon_s[b*CPB] || $isunknown(mon_s[b*CPB+j])) ok = 0;
            for (int i = 0; i < 8; i++) v[i] = mon_s[CPB*(i+1)];
            rx_val_q.push_back(v);
            rx_ok_q.push_back(ok);
            rx_busy_q.push_back(mon_busy_ok);
            rx_gap_q.push_back(mon_gap);
            rx_par_q.push_back(mon_s[9*CPB]);
            mon_active = 0;
            mon_high   = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int c = 0;
      while (rx_val_q.size() < n && c < budget) begin
         tick();
         c++;
      end
      ok = (rx_val_q.size() >= n);
   endtask

   task automatic pop_frame(output logic [7:0] v, output bit ok, output bit bsy, output int gap,
                            output logic par);
      v   = rx_val_q.pop_front();
      ok  = rx_ok_q.pop_front();
      bsy = rx_busy_q.pop_front();
      gap = rx_gap_q.pop_front();
      par = rx_par_q.pop_front();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      data_in = 8'd0;
      repeat (3) tick();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
      checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count); end
      reset_n = 1'b1;
      repeat (10) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
      checks++; if (rx_val_q.size() != 0) begin errors++; $display("FAIL idle_frames: got %0d expected 0", rx_val_q.size()); end
   endtask

   task automatic test_single_change();
      logic [7:0] v; bit ok, bsy, got; int gap; logic par;
      data_in = 8'd1;
      tick();
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL lat_k: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
      tick();
      checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL lat_k1: got tx=%b busy=%b expected tx=1 busy=1", tx, busy); end
      tick();
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL lat_k2: got tx=%b expected 0", tx); end
      wait_frames(1, 200, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_timeout: got %b expected 1", got); end
      if (got) begin
         pop_frame(v, ok, bsy, gap, par);
         checks++; if (v !== 8'h01) begin errors++; $display("FAIL single_val: got %h expected 01", v); end
         checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_shape: got %b expected 1", ok); end
         checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bsy); end
      end
      checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL single_dropped: got %0d expected 0", dropped_count); end
   endtask

   task automatic check_burst(input string name, input int n);
      logic [7:0] v, e; bit ok, bsy, got; int gap; logic par;
      wait_frames(n, 60 * n + 50, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL %s_timeout: got %0d frames expected %0d", name, rx_val_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (rx_val_q.size() == 0) break;
         pop_frame(v, ok, bsy, gap, par);
         e = exp_q.pop_front();
         checks++; if (v !== e || ok !== 1'b1 || bsy !== 1'b1) begin
            errors++; $display("FAIL %s_frame%0d: got %h shape=%b busy=%b expected %h shape=1 busy=1", name, i, v, ok, bsy, e);
         end
         if (i > 0) begin
            checks++; if (gap != 1) begin errors++; $display("FAIL %s_gap%0d: got %0d expected 1", name, i, gap); end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_overflow();
      data_in = 8'd0;
      exp_q.push_back(8'h00);
      check_burst("zero", 1);
      for (int i = 1; i <= 6; i++) begin
         data_in = 8'(i);
         tick();
      end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
      checks++; if (dropped_count !== 8'd1) begin errors++; $display("FAIL ovf_dropped: got %0d expected 1", dropped_count); end
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      check_burst("ovf", 5);
      checks++; if (dropped_count !== 8'd1) begin errors++; $display("FAIL ovf_dropped_after: got %0d expected 1", dropped_count); end
   endtask

   task automatic test_wrap_hold();
      data_in = 8'd9;  tick();
      data_in = 8'd10; tick();
      data_in = 8'd0;  tick();
      exp_q.push_back(8'h09); exp_q.push_back(8'h0A); exp_q.push_back(8'h00);
      check_burst("wrap", 3);
      repeat (200) tick();
      checks++; if (rx_val_q.size() != 0) begin errors++; $display("FAIL hold_frames: got %0d expected 0", rx_val_q.size()); end
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL hold_line: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
   endtask

`ifdef COUNT_UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] v; bit ok, bsy, got; int gap; logic par;
      data_in = 8'h07;
      wait_frames(1, 200, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL par7_timeout: got %b expected 1", got); end
      if (got) begin
         pop_frame(v, ok, bsy, gap, par);
         checks++; if (v !== 8'h07 || ok !== 1'b1 || bsy !== 1'b1) begin errors++; $display("FAIL par7_frame: got %h shape=%b busy=%b expected 07 1 1", v, ok, bsy); end
         checks++; if (par !== 1'b1) begin errors++; $display("FAIL par7_bit: got %b expected 1", par); end
      end
      data_in = 8'h03;
      wait_frames(1, 200, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL par3_timeout: got %b expected 1", got); end
      if (got) begin
         pop_frame(v, ok, bsy, gap, par);
         checks++; if (v !== 8'h03 || ok !== 1'b1) begin errors++; $display("FAIL par3_frame: got %h shape=%b expected 03 1", v, ok); end
         checks++; if (par !== 1'b0) begin errors++; $display("FAIL par3_bit: got %b expected 0", par); end
      end
   endtask
`endif

   task automatic test_reset_mid_frame();
      logic [7:0] v; bit ok, bsy, got; int gap; logic par;
      data_in = 8'h05; tick();
      data_in = 8'h06; tick();
      data_in = 8'h07; tick();
      repeat (8) tick();
      #2;
      reset_n = 1'b0;
      data_in = 8'h00;
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_line: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
      checks++; if (dropped_count !== 8'd0 || fifo_full !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got dropped=%0d full=%b expected 0 0", dropped_count, fifo_full); end
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (60) tick();
      checks++; if (rx_val_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after_quiet: got frames=%0d busy=%b expected 0 0", rx_val_q.size(), busy); end
      checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL rst_after_dropped: got %0d expected 0", dropped_count); end
      data_in = 8'h04;
      wait_frames(1, 200, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rst_frame_timeout: got %b expected 1", got); end
      if (got) begin
         pop_frame(v, ok, bsy, gap, par);
         checks++; if (v !== 8'h04 || ok !== 1'b1) begin errors++; $display("FAIL rst_frame: got %h shape=%b expected 04 1", v, ok); end
      end
      repeat (100) tick();
      checks++; if (rx_val_q.size() != 0) begin errors++; $display("FAIL rst_fifo_cleared: got %0d extra frames expected 0", rx_val_q.size()); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         data_in = (i % 2 == 0) ? 8'h11 : 8'h22;
         tick();
      end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL sat_full: got %b expected 1", fifo_full); end
      checks++; if (dropped_count !== 8'd255) begin errors++; $display("FAIL sat_dropped: got %0d expected 255", dropped_count); end
      for (int i = 0; i < 20; i++) begin
         data_in = (i % 2 == 0) ? 8'h11 : 8'h22;
         tick();
      end
      checks++; if (dropped_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", dropped_count); end
   endtask

   initial begin
      reset_n = 1'b0;
      data_in = 8'd0;
      test_reset();
      test_single_change();
      test_overflow();
      test_wrap_hold();
`ifdef COUNT_UART_TX_PARITY_EN
      test_parity();
`endif
      test_reset_mid_frame();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
